// File: rtl/pipe_stage_skid.sv
// Stallable inter-stage register with a two-entry skid buffer.
// Bubbles carry an all-zero control field; stall cycles are counted.
module pipe_stage_skid #(
    parameter int N      = 32,
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N-1:0]      in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N-1:0]      out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic              main_valid_q, main_valid_d;
    logic [N-1:0]      main_data_q, main_data_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic              skid_valid_q, skid_valid_d;
    logic [N-1:0]      skid_data_q, skid_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [CNT_W-1:0]  stall_q, stall_d;
    logic              acc, drn;

    // in_ready depends on registered state only, never on out_ready
    assign in_ready  = !skid_valid_q;
    assign out_valid = main_valid_q;
    assign out_data  = main_data_q;
    assign out_ctrl  = main_valid_q ? main_ctrl_q : '0;
    assign stall_cnt = stall_q;

    assign acc = in_valid & in_ready;
    assign drn = main_valid_q & out_ready;

    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        main_ctrl_d  = main_ctrl_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_ctrl_d  = skid_ctrl_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q) begin
            if (acc) begin
                main_valid_d = 1'b1;
                main_data_d  = in_data;
                main_ctrl_d  = in_ctrl;
            end
        end else if (!skid_valid_q) begin
            if (acc && drn) begin
                main_data_d = in_data;
                main_ctrl_d = in_ctrl;
            end else if (acc) begin
                skid_valid_d = 1'b1;
                skid_data_d  = in_data;
                skid_ctrl_d  = in_ctrl;
            end else if (drn) begin
                main_valid_d = 1'b0;
            end
        end else if (drn) begin
            main_data_d  = skid_data_q;
            main_ctrl_d  = skid_ctrl_q;
            skid_valid_d = 1'b0;
        end
    end

    // Saturating; flush does not touch it
    always_comb begin
        stall_d = stall_q;
        if (main_valid_q && !out_ready && stall_q != '1)
            stall_d = stall_q + CNT_W'(1);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            main_valid_q <= 1'b0;
            main_data_q  <= '0;
            main_ctrl_q  <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_ctrl_q  <= '0;
            stall_q      <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            main_ctrl_q  <= main_ctrl_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_ctrl_q  <= skid_ctrl_d;
            stall_q      <= stall_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: reset, streaming, skid,
// flush, bubble gating and stall-counter saturation.
module tb_pipe_stage_skid;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic [7:0]  in_ctrl = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic [7:0]  out_ctrl;
    logic [15:0] stall_cnt;

    logic        s_in_valid = 1'b0;
    logic        s_in_ready;
    logic [31:0] s_out_data;
    logic [7:0]  s_out_ctrl;
    logic        s_out_valid;
    logic [3:0]  s_stall_cnt;

    int n_chk = 0;
    int n_pass = 0;

    always #5 CLK = ~CLK;

    pipe_stage_skid #(.N(32), .CTRL_W(8), .CNT_W(16)) u_dut (
        .CLK(CLK), .RST(RST),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_ctrl(in_ctrl),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_ctrl(out_ctrl),
        .stall_cnt(stall_cnt)
    );

    pipe_stage_skid #(.N(32), .CTRL_W(8), .CNT_W(4)) u_sat (
        .CLK(CLK), .RST(RST),
        .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_data(32'h5A), .in_ctrl(8'h01),
        .flush(1'b0),
        .out_valid(s_out_valid), .out_ready(1'b0),
        .out_data(s_out_data), .out_ctrl(s_out_ctrl),
        .stall_cnt(s_stall_cnt)
    );

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input logic [7:0] c);
        in_valid = 1'b1;
        in_data  = d;
        in_ctrl  = c;
    endtask

    initial begin
        step();
        step();
        check("rst_ov", out_valid, 0);
        check("rst_od", out_data, 0);
        check("rst_oc", out_ctrl, 0);
        check("rst_ir", in_ready, 1);
        check("rst_sc", stall_cnt, 0);
        RST = 1'b1;

        // streaming with out_ready held high
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            send(32'(i), 8'(i + 8'h40));
            step();
            check($sformatf("str_v%0d", i), out_valid, 1);
            check($sformatf("str_d%0d", i), out_data, i);
            check($sformatf("str_c%0d", i), out_ctrl, i + 8'h40);
        end
        in_valid = 1'b0;
        step();
        check("str_end_v", out_valid, 0);
        check("str_sc", stall_cnt, 0);

        // skid: 0x10 lands, then stall
        out_ready = 1'b0;
        send(32'h10, 8'h81);
        step();
        check("skd_d10", out_data, 32'h10);
        check("skd_ir1", in_ready, 1);
        send(32'h11, 8'h82);
        step();
        check("skd_ir0", in_ready, 0);
        check("skd_sc1", stall_cnt, 1);
        send(32'h12, 8'h83);
        step();
        check("skd_hold", out_data, 32'h10);
        check("skd_holdc", out_ctrl, 8'h81);
        check("skd_ir0b", in_ready, 0);
        step();
        check("skd_sc3", stall_cnt, 3);
        out_ready = 1'b1;
        step();
        check("skd_d11", out_data, 32'h11);
        check("skd_c11", out_ctrl, 8'h82);
        check("skd_ir1b", in_ready, 1);
        step();
        check("skd_d12", out_data, 32'h12);
        in_valid = 1'b0;
        step();
        check("skd_emp", out_valid, 0);
        check("skd_scf", stall_cnt, 3);

        // flush from FULL with an incoming beat
        out_ready = 1'b0;
        send(32'h20, 8'h11);
        step();
        send(32'h21, 8'h12);
        step();
        check("fl_full", in_ready, 0);
        send(32'h99, 8'h77);
        flush = 1'b1;
        step();
        check("fl_ov", out_valid, 0);
        check("fl_ir", in_ready, 1);
        check("fl_oc", out_ctrl, 0);
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        check("fl_no99", out_valid, 0);
        check("fl_sc", stall_cnt, 5);

        // bubble ctrl must never leak
        in_valid = 1'b0;
        in_ctrl = 8'hFF;
        in_data = 32'hDEAD;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("bub_c%0d", i), out_ctrl, 0);
            check($sformatf("bub_v%0d", i), out_valid, 0);
        end

        // asynchronous reset while FULL
        out_ready = 1'b0;
        send(32'h30, 8'h21);
        step();
        send(32'h31, 8'h22);
        step();
        check("ar_full", in_ready, 0);
        in_valid = 1'b0;
        #2;
        RST = 1'b0;
        #1;
        check("ar_ov", out_valid, 0);
        check("ar_oc", out_ctrl, 0);
        check("ar_od", out_data, 0);
        check("ar_ir", in_ready, 1);
        check("ar_sc", stall_cnt, 0);
        step();
        RST = 1'b1;

        // first beat after release
        out_ready = 1'b1;
        send(32'hA5A5A5A5, 8'h3C);
        check("a5_pre", out_valid, 0);
        step();
        check("a5_v", out_valid, 1);
        check("a5_d", out_data, 32'hA5A5A5A5);
        check("a5_c", out_ctrl, 8'h3C);
        in_valid = 1'b0;
        step();
        check("a5_gone", out_valid, 0);

        // saturation on the 4-bit counter instance
        s_in_valid = 1'b1;
        step();
        s_in_valid = 1'b0;
        check("sat_v", s_out_valid, 1);
        check("sat_0", s_stall_cnt, 0);
        for (int i = 1; i <= 20; i++) begin
            step();
            if (i == 14) check("sat_14", s_stall_cnt, 14);
            if (i == 15) check("sat_15", s_stall_cnt, 15);
        end
        check("sat_hold", s_stall_cnt, 15);
        check("sat_data", s_out_data, 32'h5A);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised pipeline stage register with a valid/ready handshake, a two-entry skid buffer, synchronous flush and a stall-cycle counter. It replaces fixed-field, non-stallable inter-stage registers (IF/ID … MEM/WB) in the processor pipeline. It carries an arbitrary data payload plus a control field whose write-enable bits are forced to zero for bubbles. Both entries are clocked on the rising edge of one clock.

## Interface
Parameters:
- N, 32, data payload width (ALU result, read data, etc., concatenated by the instantiating stage)
- CTRL_W, 8, control field width (RF_WE, MemWE, WBSelect, A3, …)
- CNT_W, 16, stall counter width

Ports:
- CLK  input  1  clock; all state updates on rising edge
- RST  input  1  reset, asynchronous, active-low
- in_valid  input  1  upstream beat present
- in_ready  output  1  stage can accept a beat this cycle
- in_data  input  N  upstream payload
- in_ctrl  input  CTRL_W  upstream control field
- flush  input  1  synchronous discard of all held and incoming beats
- out_valid  output  1  downstream beat present
- out_ready  input  1  downstream accepts beat this cycle
- out_data  output  N  payload of head entry
- out_ctrl  output  CTRL_W  control of head entry, all-zero when out_valid=0
- stall_cnt  output  CNT_W  saturating count of back-pressured cycles

## Operation
- Storage: main entry (drives outputs) and skid entry; each holds a valid bit, data and ctrl.
- State is encoded by the valid bits: EMPTY (none), ONE (main only), FULL (main and skid). Skid-only is illegal.
- in_ready = !skid_valid. It is a function of registered state only, with no combinational path from out_ready.
- Accept: acc = in_valid & in_ready. Drain: drn = out_valid & out_ready.
- Transitions when flush=0:
  - EMPTY: acc → main←in, ONE. Otherwise stay.
  - ONE: acc&drn → main←in, ONE. acc&!drn → skid←in, FULL. !acc&drn → EMPTY. Otherwise hold.
  - FULL: drn → main←skid, ONE. Otherwise hold. No accept is possible because in_ready=0.
- flush=1: both valid bits clear on the next edge and the state becomes EMPTY. A beat offered in the same cycle is discarded. A drain in the same cycle still completes downstream. Data/ctrl registers are not cleared. flush takes priority over every other event.
- out_data = main data. out_ctrl = main ctrl when main_valid, else 0. This zero gating prevents a bubble from asserting register-file or memory write enables.
- stall_cnt increments on each cycle with out_valid=1 & out_ready=0. It saturates at 2^CNT_W−1 and does not wrap. It is unaffected by flush and clears only on reset.

## Timing
- Reset (RST=0, asynchronous): valid bits=0, data/ctrl=0, stall_cnt=0. Outputs are therefore out_valid=0, out_data=0, out_ctrl=0, in_ready=1, stall_cnt=0. Reset release is synchronised by the instantiating top level.
- Reset asserted mid-operation discards both entries immediately, without waiting for an edge.
- Latency: a beat accepted at edge k is visible on out_* after edge k, i.e. one cycle.
- Throughput: one beat per cycle while out_ready=1.
- Back-pressure: in_ready drops one cycle after out_ready deasserts with a beat arriving. The skid entry absorbs that beat, so none is lost.
- Ordering: strictly FIFO. A beat is never duplicated or dropped except by flush or reset.
- A held beat keeps out_data/out_ctrl stable while out_valid=1 & out_ready=0.

## Test plan
- Reset: drive RST=0 mid-stream with FULL state → out_valid=0, out_ctrl=0, in_ready=1, stall_cnt=0 before the next edge. After release, first beat 0xA5A5A5A5 appears one cycle after acceptance.
- Streaming: out_ready=1, send 0x1..0x8 on consecutive cycles → 0x1..0x8 out in order, one per cycle, latency 1, stall_cnt=0.
- Skid: send 0x10, 0x11, 0x12 with out_ready=0 from the cycle 0x10 lands → state FULL holding 0x10/0x11, in_ready=0, 0x12 held upstream. Release out_ready → 0x10, 0x11, 0x12 out in order. stall_cnt equals the stalled cycles.
- Flush: FULL state plus flush=1 with in_valid=1 (0x99) → next cycle out_valid=0, in_ready=1, 0x99 never appears, out_ctrl=0.
- Bubble gating: in_ctrl=0xFF on a beat with in_valid=0 → out_ctrl remains 0x00 throughout.
- Saturation: CNT_W=4, hold out_valid=1 with out_ready=0 for 20 cycles → stall_cnt reaches 15 and holds 15.
